// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with an init sweep and a busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRP   = 3,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    output logic                ready_o,
    input  logic [NRP*AW-1:0]   rd_addr_i,
    output logic [NRP*XLEN-1:0] rd_data_o,
    output logic [NRP-1:0]      rd_busy_o,
    input  logic                wr0_en_i,
    input  logic [AW-1:0]       wr0_addr_i,
    input  logic [XLEN-1:0]     wr0_data_i,
    input  logic                wr1_en_i,
    input  logic [AW-1:0]       wr1_addr_i,
    input  logic [XLEN-1:0]     wr1_data_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i
);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     sweep_q, sweep_d;
    logic [NREGS-1:0]  busy_q, set_m, clr_m;
    logic [XLEN-1:0]   regs [NREGS];
    logic [AW-1:0]     ra;
    logic              run;

    assign run     = state_q == RUN;
    assign ready_o = run;

    // state and sweep index register; reset restarts the sweep from register 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // sweep advances one register per cycle and hands over to RUN after the last one
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == INIT) begin
            sweep_d = sweep_q + 1'b1;
            state_d = (sweep_q == AW'(NREGS - 1)) ? RUN : INIT;
        end
    end

    // storage has no reset so it can map to RAM; the sweep zeroes it, wr1 lands last
    always_ff @(posedge clk_i) begin
        if (!run) begin
            regs[sweep_q] <= '0;
        end else begin
            if (wr0_en_i && wr0_addr_i != '0) regs[wr0_addr_i] <= wr0_data_i;
            if (wr1_en_i && wr1_addr_i != '0) regs[wr1_addr_i] <= wr1_data_i;
        end
    end

    // scoreboard set/clear masks; register 0 is never marked busy
    always_comb begin
        set_m = '0;
        clr_m = '0;
        if (iss_en_i && iss_addr_i != '0) set_m[iss_addr_i] = 1'b1;
        if (wr0_en_i) clr_m[wr0_addr_i] = 1'b1;
        if (wr1_en_i) clr_m[wr1_addr_i] = 1'b1;
    end

    // busy vector: writes clear, a same-cycle issue overrides the clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= '0;
        else if (run) busy_q <= (busy_q & ~clr_m) | set_m;
    end

    // combinational read ports, zero during the sweep and for register 0
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        ra        = '0;
        for (int k = 0; k < NRP; k++) begin
            ra = rd_addr_i[k*AW +: AW];
`ifdef REGFILE_MP_BYPASS_EN
            rd_data_o[k*XLEN +: XLEN] = (!run || ra == '0) ? '0 :
                                        (wr1_en_i && wr1_addr_i == ra) ? wr1_data_i :
                                        (wr0_en_i && wr0_addr_i == ra) ? wr0_data_i : regs[ra];
            rd_busy_o[k] = run && ra != '0 && busy_q[ra] &&
                           !((wr0_en_i && wr0_addr_i == ra) || (wr1_en_i && wr1_addr_i == ra));
`else
            rd_data_o[k*XLEN +: XLEN] = (!run || ra == '0) ? '0 : regs[ra];
            rd_busy_o[k] = run && ra != '0 && busy_q[ra];
`endif
        end
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the data width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning the register count (power of two, >=4); AW = $clog2(NREGS).
REQ-003 The block SHALL have parameter NRP, default 3, meaning the number of read ports.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port ready_o, output, 1 bit: init sweep finished, block accepts traffic.
REQ-007 The block SHALL have port rd_addr_i, input, NRP*AW bits: read addresses, port k at [k*AW +: AW].
REQ-008 The block SHALL have port rd_data_o, output, NRP*XLEN bits: read data, combinational, port k at [k*XLEN +: XLEN].
REQ-009 The block SHALL have port rd_busy_o, output, NRP bits: scoreboard busy flag of each read address.
REQ-010 The block SHALL have ports wr0_en_i (1), wr0_addr_i (AW) and wr0_data_i (XLEN), all inputs: write port 0.
REQ-011 The block SHALL have ports wr1_en_i (1), wr1_addr_i (AW) and wr1_data_i (XLEN), all inputs: write port 1.
REQ-012 The block SHALL have ports iss_en_i (1) and iss_addr_i (AW), both inputs: issue, which marks a destination busy.

Function
REQ-013 The block SHALL implement a two-state FSM with states INIT and RUN.
REQ-014 In INIT the block SHALL zero one register per cycle at index sweep_cnt, incrementing 0..NREGS-1, then enter RUN.
REQ-015 ready_o SHALL be 1 exactly in RUN, i.e. NREGS cycles after the first clock edge following reset release.
REQ-016 In INIT, writes and issues SHALL be ignored, rd_data_o SHALL read all zero and rd_busy_o SHALL be 0.
REQ-017 In RUN, a write port with en=1 and addr!=0 SHALL store its data at the rising edge.
REQ-018 Both write ports to the same nonzero address in one cycle SHALL store wr1 data (wr1 has priority).
REQ-019 Register 0 SHALL always read 0 and never be busy; writes and issues to address 0 SHALL be ignored.
REQ-020 Read data SHALL be the stored value of the addressed register, combinational, zero-cycle latency.
REQ-021 The scoreboard SHALL be a NREGS-bit busy vector: an issue sets bit iss_addr_i, and each enabled write clears bit wrN_addr_i.
REQ-022 An issue and a write to the same register in one cycle SHALL leave the bit set (issue wins).
REQ-023 rd_busy_o[k] SHALL equal the busy bit at rd_addr k, and SHALL be 0 when that address is being written this cycle while bypass is enabled.
REQ-024 All reads of the same address SHALL return identical values on every port.

Reset
REQ-025 rst_ni low SHALL asynchronously force state to INIT, sweep_cnt to 0, busy vector to 0 and ready_o to 0.
REQ-026 The register array SHALL NOT be reset directly; the INIT sweep clears it, so it can map to RAM.
REQ-027 Reset asserted mid-sweep or mid-RUN SHALL restart the full sweep from index 0.

Configuration
REQ-028 Macro REGFILE_MP_BYPASS_EN, when defined, SHALL forward the written data to any read port whose nonzero address matches an enabled write in the same cycle; wr1 data SHALL be forwarded when both write ports match.
REQ-029 Without REGFILE_MP_BYPASS_EN, reads SHALL return the pre-edge stored value and rd_busy_o SHALL show the uncleared busy bit.

Verification
REQ-030 Reset with NREGS=32: ready_o is 0 for 32 cycles then 1, all reads return 0, and a write issued during INIT is lost.
REQ-031 In RUN, wr0 writes x5=0xDEADBEEF; next cycle a read of 5 on all ports returns 0xDEADBEEF; a write of 0x1234 to x0 reads back 0.
REQ-032 Both ports write x7 (wr0=0x11, wr1=0x22) -> x7 reads 0x22; with bypass, the same-cycle read of 7 also returns 0x22.
REQ-033 Issue x9, then busy=1; a later wr0 to x9 clears busy; issue x9 plus wr1 to x9 in the same cycle leaves busy=1.
REQ-034 Without bypass, write x3=0xA5 while reading 3 -> the read returns the old value that cycle and 0xA5 the next cycle.
REQ-035 Assert rst_ni at sweep index 10 -> ready_o drops, the sweep restarts from 0, and ready_o rises 32 cycles after release.
